// File: rtl/lsu_axil.sv
// Load/store unit bridging the core memory stage to an AXI4-Lite master port.
// One transaction in flight; misalignment, bus errors and response timeouts fold into one error flag.
module lsu_axil #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  input  logic [1:0]          req_size_i,
  input  logic                req_unsigned_i,
  output logic                rsp_valid_o,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                rsp_err_o,
  output logic [ADDR_W-1:0]   m_awaddr_o,
  output logic                m_awvalid_o,
  input  logic                m_awready_i,
  output logic [DATA_W-1:0]   m_wdata_o,
  output logic [DATA_W/8-1:0] m_wstrb_o,
  output logic                m_wvalid_o,
  input  logic                m_wready_i,
  input  logic [1:0]          m_bresp_i,
  input  logic                m_bvalid_i,
  output logic                m_bready_o,
  output logic [ADDR_W-1:0]   m_araddr_o,
  output logic                m_arvalid_o,
  input  logic                m_arready_i,
  input  logic [DATA_W-1:0]   m_rdata_i,
  input  logic [1:0]          m_rresp_i,
  input  logic                m_rvalid_i,
  output logic                m_rready_o
);
  localparam int unsigned OFF    = $clog2(DATA_W / 8);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_REQ  = 3'd1;
  localparam logic [2:0] ST_WR_RESP = 3'd2;
  localparam logic [2:0] ST_RD_REQ  = 3'd3;
  localparam logic [2:0] ST_RD_DATA = 3'd4;
  localparam logic [2:0] ST_RESP    = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic              unsigned_q, unsigned_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [OFF-1:0]    off;
  logic              misaligned;
  logic              timeout_hit;
  logic [STRB_W-1:0] size_mask;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_ext;
  logic              unused_resp_lsb;

  assign off             = addr_q[OFF-1:0];
  assign timeout_hit     = (TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST);
  assign unused_resp_lsb = m_bresp_i[0] ^ m_rresp_i[0];

  always_comb begin
    case (req_size_i)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = req_addr_i[0];
      2'd2:    misaligned = |req_addr_i[1:0];
      default: misaligned = (DATA_W == 32) || (|req_addr_i[2:0]);
    endcase
  end

  always_comb begin
    case (size_q)
      2'd0:    size_mask = STRB_W'(8'h01);
      2'd1:    size_mask = STRB_W'(8'h03);
      2'd2:    size_mask = STRB_W'(8'h0F);
      default: size_mask = STRB_W'(8'hFF);
    endcase
  end

  // Load lane extraction: bring the addressed bytes down to bit 0, then extend.
  always_comb begin
    r_shift = m_rdata_i >> {off, 3'b000};
    case (size_q)
      2'd0:    r_ext = unsigned_q ? DATA_W'(r_shift[7:0])  : DATA_W'($signed(r_shift[7:0]));
      2'd1:    r_ext = unsigned_q ? DATA_W'(r_shift[15:0]) : DATA_W'($signed(r_shift[15:0]));
      2'd2:    r_ext = unsigned_q ? DATA_W'(r_shift[31:0]) : DATA_W'($signed(r_shift[31:0]));
      default: r_ext = r_shift;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          addr_d     = req_addr_i;
          wdata_d    = req_wdata_i;
          size_d     = req_size_i;
          unsigned_d = req_unsigned_i;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          rdata_d    = '0;
          cnt_d      = '0;
          err_d      = misaligned;
          if (misaligned)    state_d = ST_RESP;
          else if (req_we_i) state_d = ST_WR_REQ;
          else               state_d = ST_RD_REQ;
        end
      end
      ST_WR_REQ: begin
        if (m_awready_i) aw_done_d = 1'b1;
        if (m_wready_i)  w_done_d  = 1'b1;
        if ((aw_done_q || m_awready_i) && (w_done_q || m_wready_i)) begin
          state_d = ST_WR_RESP;
          cnt_d   = '0;
        end
      end
      ST_WR_RESP: begin
        if (m_bvalid_i) begin
          err_d   = m_bresp_i[1];
          state_d = ST_RESP;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RD_REQ: begin
        if (m_arready_i) begin
          state_d = ST_RD_DATA;
          cnt_d   = '0;
        end
      end
      ST_RD_DATA: begin
        if (m_rvalid_i) begin
          err_d   = m_rresp_i[1];
          rdata_d = m_rresp_i[1] ? '0 : r_ext;
          state_d = ST_RESP;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      unsigned_q <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
    end
  end

  // Every output decodes from flops only, so no input reaches an output combinationally.
  assign req_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_err_o   = (state_q == ST_RESP) && err_q;
  assign rsp_rdata_o = (state_q == ST_RESP) ? rdata_q : '0;
  assign m_awaddr_o  = {addr_q[ADDR_W-1:OFF], {OFF{1'b0}}};
  assign m_araddr_o  = {addr_q[ADDR_W-1:OFF], {OFF{1'b0}}};
  assign m_awvalid_o = (state_q == ST_WR_REQ) && !aw_done_q;
  assign m_wvalid_o  = (state_q == ST_WR_REQ) && !w_done_q;
  assign m_wdata_o   = wdata_q << {off, 3'b000};
  assign m_wstrb_o   = size_mask << off;
  assign m_bready_o  = (state_q == ST_WR_RESP);
  assign m_arvalid_o = (state_q == ST_RD_REQ);
  assign m_rready_o  = (state_q == ST_RD_DATA);

endmodule

// File: tb/tb_lsu_axil.sv
// Randomised bench for lsu_axil: an AXI4-Lite slave with per-channel delays and
// error/no-response knobs, checked against a byte-addressed memory reference model.
module tb_lsu_axil;
  localparam int TO = 8;

  logic        clk_sys = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_ready_o, rsp_valid_o, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic [31:0] m_awaddr_o, m_wdata_o, m_araddr_o;
  logic [3:0]  m_wstrb_o;
  logic        m_awvalid_o, m_wvalid_o, m_bready_o, m_arvalid_o, m_rready_o;
  logic        m_awready_i = 1'b0, m_wready_i = 1'b0, m_bvalid_i = 1'b0;
  logic        m_arready_i = 1'b0, m_rvalid_i = 1'b0;
  logic [1:0]  m_bresp_i = '0, m_rresp_i = '0;
  logic [31:0] m_rdata_i = '0;

  int n_chk = 0, n_err = 0, cyc = 0;

  // slave knobs, written by the stimulus process only
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0] bresp_k = 2'b00, rresp_k = 2'b00;
  logic no_resp = 1'b0;

  // slave state, written by the slave process only
  logic [31:0] smem [64];
  logic        mem_init = 1'b0;
  logic        aw_got = 0, w_got = 0, ar_got = 0;
  logic        aw_hs_p = 0, w_hs_p = 0, b_hs_p = 0, ar_hs_p = 0, r_hs_p = 0;
  int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  int          aw_hs_n = 0, w_hs_n = 0, ar_hs_n = 0, bad_bready = 0, rready_cyc = 0;
  logic [31:0] cap_awaddr = '0, cap_araddr = '0, cap_wdata = '0;
  logic [3:0]  cap_wstrb = '0;

  logic [7:0]  ref_mem [256];

  lsu_axil #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk_sys), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_size_i(req_size),
    .req_unsigned_i(req_unsigned),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .m_awaddr_o(m_awaddr_o), .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i),
    .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o), .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i),
    .m_bresp_i(m_bresp_i), .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o),
    .m_araddr_o(m_araddr_o), .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
    .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i), .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  function automatic logic [31:0] word_init(input int i);
    return 32'(32'h9E3779B9 * 32'(i + 1)) ^ 32'h5A5A1234;
  endfunction

  // Slave: handshakes of the preceding rising edge are retired first, then the
  // outputs for the coming edge are decided.
  always @(negedge clk_sys) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) smem[i] = word_init(i);
      mem_init = 1'b1;
    end
    if (aw_hs_p) begin aw_got = 1'b1; aw_hs_n++; end
    if (w_hs_p)  begin w_got = 1'b1;  w_hs_n++;  end
    if (b_hs_p) begin
      if (!bresp_k[1])
        for (int i = 0; i < 4; i++)
          if (cap_wstrb[i]) smem[cap_awaddr[7:2]][8*i +: 8] = cap_wdata[8*i +: 8];
      m_bvalid_i = 1'b0; aw_got = 1'b0; w_got = 1'b0; b_cnt = 0;
    end
    if (ar_hs_p) begin ar_hs_n++; rready_cyc = 0; if (!no_resp) ar_got = 1'b1; end
    if (r_hs_p)  begin m_rvalid_i = 1'b0; ar_got = 1'b0; r_cnt = 0; end
    if (m_bready_o && !(aw_got && w_got)) bad_bready++;
    if (m_rready_o) rready_cyc++;

    m_awready_i = m_awvalid_o && (aw_cnt >= aw_dly);
    if (m_awvalid_o && !m_awready_i) aw_cnt++; else aw_cnt = 0;
    if (m_awready_i) cap_awaddr = m_awaddr_o;
    m_wready_i = m_wvalid_o && (w_cnt >= w_dly);
    if (m_wvalid_o && !m_wready_i) w_cnt++; else w_cnt = 0;
    if (m_wready_i) begin cap_wdata = m_wdata_o; cap_wstrb = m_wstrb_o; end
    if (aw_got && w_got && !m_bvalid_i && !no_resp) begin
      if (b_cnt >= b_dly) begin m_bvalid_i = 1'b1; m_bresp_i = bresp_k; end
      else b_cnt++;
    end
    m_arready_i = m_arvalid_o && (ar_cnt >= ar_dly);
    if (m_arvalid_o && !m_arready_i) ar_cnt++; else ar_cnt = 0;
    if (m_arready_i) cap_araddr = m_araddr_o;
    if (ar_got && !m_rvalid_i) begin
      if (r_cnt >= r_dly) begin
        m_rvalid_i = 1'b1; m_rdata_i = smem[cap_araddr[7:2]]; m_rresp_i = rresp_k;
      end else r_cnt++;
    end

    aw_hs_p = m_awvalid_o && m_awready_i;
    w_hs_p  = m_wvalid_o && m_wready_i;
    b_hs_p  = m_bvalid_i && m_bready_o;
    ar_hs_p = m_arvalid_o && m_arready_i;
    r_hs_p  = m_rvalid_i && m_rready_o;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One request through the DUT; expectations come from the byte memory model and knobs.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [1:0] sz, input logic uns, output logic [31:0] rd);
    int nb, k, t0, exp_lat, aw0, w0, ar0, off;
    logic mis, exp_err;
    logic [31:0] v, exp_rd, exp_wd, wmask;
    logic [3:0] exp_strb;
    nb  = 1 << sz;
    off = int'(addr[1:0]);
    mis = (sz == 2'd3) || ((addr % nb) != 0);
    exp_err = mis || (we ? bresp_k[1] : (no_resp || rresp_k[1]));
    if (mis)          exp_lat = 1;
    else if (we)      exp_lat = 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly;
    else if (no_resp) exp_lat = 2 + ar_dly + TO;
    else              exp_lat = 3 + ar_dly + r_dly;
    exp_strb = '0; exp_wd = '0; wmask = '0; v = '0;
    if (!mis)
      for (int i = 0; i < nb; i++) begin
        exp_strb[off + i] = 1'b1;
        exp_wd[8*(off + i) +: 8] = wd[8*i +: 8];
        wmask[8*(off + i) +: 8] = 8'hFF;
        v[8*i +: 8] = ref_mem[(addr + i) & 255];
      end
    if (!mis && !uns && v[8*nb - 1])
      for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
    exp_rd = (we || exp_err) ? 32'h0 : v;
    aw0 = aw_hs_n; w0 = w_hs_n; ar0 = ar_hs_n;

    @(negedge clk_sys);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    req_size = sz; req_unsigned = uns;
    k = 0;
    while (!req_ready_o && k < 50) begin @(negedge clk_sys); k++; end
    chk("req_ready_idle", req_ready_o, 1'b1);
    t0 = cyc;
    @(negedge clk_sys);
    req_valid = 1'b0;
    chk("req_ready_busy", req_ready_o, 1'b0);
    k = 0;
    while (!rsp_valid_o && k < 100) begin @(negedge clk_sys); k++; end
    chk("rsp_seen", rsp_valid_o, 1'b1);
    chk("latency", cyc - t0, exp_lat);
    chk("rsp_err", rsp_err_o, exp_err);
    chk("rsp_rdata", rsp_rdata_o, exp_rd);
    chk("rready_in_resp", m_rready_o, 1'b0);
    rd = rsp_rdata_o;
    @(negedge clk_sys);
    chk("rsp_single_pulse", rsp_valid_o, 1'b0);
    chk("req_ready_back", req_ready_o, 1'b1);
    chk("aw_hs_count", aw_hs_n - aw0, (!mis && we) ? 1 : 0);
    chk("w_hs_count", w_hs_n - w0, (!mis && we) ? 1 : 0);
    chk("ar_hs_count", ar_hs_n - ar0, (!mis && !we) ? 1 : 0);
    if (!mis && we) begin
      chk("wstrb", cap_wstrb, exp_strb);
      chk("wdata_lanes", cap_wdata & wmask, exp_wd);
      chk("awaddr", cap_awaddr, addr & ~32'h3);
    end
    if (!mis && !we) chk("araddr", cap_araddr, addr & ~32'h3);
    if (we && !exp_err)
      for (int i = 0; i < nb; i++) ref_mem[(addr + i) & 255] = wd[8*i +: 8];
  endtask

  initial begin
    logic [31:0] rd, w;
    logic        we, uns;
    logic [1:0]  sz;
    for (int a = 0; a < 256; a++) begin
      w = word_init(a >> 2);
      ref_mem[a] = w[8*(a % 4) +: 8];
    end

    @(negedge clk_sys); @(negedge clk_sys);
    chk("rst_awvalid", m_awvalid_o, 1'b0);
    chk("rst_wvalid", m_wvalid_o, 1'b0);
    chk("rst_arvalid", m_arvalid_o, 1'b0);
    chk("rst_bready", m_bready_o, 1'b0);
    chk("rst_rready", m_rready_o, 1'b0);
    chk("rst_rsp_valid", rsp_valid_o, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata_o, 32'h0);
    chk("rst_rsp_err", rsp_err_o, 1'b0);
    rst_n = 1'b1;

    do_req(1'b1, 32'h100, 32'hDEADBEEF, 2'd2, 1'b0, rd);
    chk("word_wstrb", cap_wstrb, 4'hF);
    do_req(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, rd);
    chk("word_load", rd, 32'hDEADBEEF);

    do_req(1'b1, 32'h103, 32'h000000A5, 2'd0, 1'b0, rd);
    chk("byte_wdata_exact", cap_wdata, 32'hA5000000);
    chk("byte_wstrb", cap_wstrb, 4'h8);
    do_req(1'b0, 32'h103, 32'h0, 2'd0, 1'b0, rd);
    chk("byte_load_signed", rd, 32'hFFFFFFA5);
    do_req(1'b0, 32'h103, 32'h0, 2'd0, 1'b1, rd);
    chk("byte_load_unsigned", rd, 32'h000000A5);

    aw_dly = 0; w_dly = 3;
    do_req(1'b1, 32'h108, 32'h12345678, 2'd2, 1'b0, rd);
    aw_dly = 3; w_dly = 0;
    do_req(1'b1, 32'h10E, 32'h0000BEEF, 2'd1, 1'b0, rd);
    aw_dly = 0;
    chk("bready_before_both", bad_bready, 0);

    do_req(1'b0, 32'h101, 32'h0, 2'd1, 1'b0, rd);
    do_req(1'b0, 32'h100, 32'h0, 2'd3, 1'b0, rd);
    do_req(1'b1, 32'h108, 32'hFFFFFFFF, 2'd3, 1'b0, rd);

    rresp_k = 2'b10;
    do_req(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, rd);
    rresp_k = 2'b00; bresp_k = 2'b11;
    do_req(1'b1, 32'h104, 32'hCAFEF00D, 2'd2, 1'b0, rd);
    bresp_k = 2'b00;

    no_resp = 1'b1;
    do_req(1'b0, 32'h110, 32'h0, 2'd2, 1'b0, rd);
    chk("rready_cycles_timeout", rready_cyc, TO);
    no_resp = 1'b0;

    // reset in the middle of a stalled store write request
    aw_dly = 40; w_dly = 40;
    @(negedge clk_sys);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h11C; req_wdata = 32'h55AA55AA; req_size = 2'd2;
    @(negedge clk_sys);
    req_valid = 1'b0;
    chk("awvalid_pre_rst", m_awvalid_o, 1'b1);
    chk("wvalid_pre_rst", m_wvalid_o, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("awvalid_async_rst", m_awvalid_o, 1'b0);
    chk("wvalid_async_rst", m_wvalid_o, 1'b0);
    chk("rsp_valid_async_rst", rsp_valid_o, 1'b0);
    @(negedge clk_sys);
    rst_n = 1'b1; aw_dly = 0; w_dly = 0;
    do_req(1'b0, 32'h11C, 32'h0, 2'd2, 1'b0, rd);

    for (int n = 0; n < 80; n++) begin
      we  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      bresp_k = {($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1))};
      rresp_k = {($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1))};
      do_req(we, 32'h100 + 32'($urandom_range(0, 255)), $urandom, sz, uns, rd);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/lsu_axil.md
# lsu_axil

Parametrised load/store unit connecting the core's memory stage to an AXI4-Lite master port. It accepts one load or store per request handshake and generates byte strobes and lane shifting for byte, half, word and (when DATA_W=64) double accesses. It sign- or zero-extends load data and reports misalignment, bus errors and response timeouts as a single error flag. Only one transaction is in flight at a time.

## Interface
- ADDR_W, 32, address width.
- DATA_W, 32, data width; legal values are 32 and 64. OFF = log2(DATA_W/8).
- TIMEOUT_CYC, 256, number of cycles to wait for B or R before aborting; 0 disables the timeout.
- clk_i  in  1  clock; all logic is clocked on the rising edge.
- rst_n_i  in  1  reset; asynchronous, active-low.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when high together with req_valid_i.
- req_we_i  in  1  1 = store, 0 = load.
- req_addr_i  in  ADDR_W  byte address.
- req_wdata_i  in  DATA_W  store data, right-aligned.
- req_size_i  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double.
- req_unsigned_i  in  1  load zero-extends when 1, sign-extends when 0.
- rsp_valid_o  out  1  single-cycle completion pulse.
- rsp_rdata_o  out  DATA_W  extended load data; 0 for stores and for errors.
- rsp_err_o  out  1  error flag, valid while rsp_valid_o is high.
- m_awaddr_o / m_awvalid_o / m_awready_i: AXI AW channel, ADDR_W / 1 / 1.
- m_wdata_o / m_wstrb_o / m_wvalid_o / m_wready_i: AXI W channel, DATA_W / DATA_W/8 / 1 / 1.
- m_bresp_i / m_bvalid_i / m_bready_o: AXI B channel, 2 / 1 / 1.
- m_araddr_o / m_arvalid_o / m_arready_i: AXI AR channel, ADDR_W / 1 / 1.
- m_rdata_i / m_rresp_i / m_rvalid_i / m_rready_o: AXI R channel, DATA_W / 2 / 1 / 1.

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESP.
- IDLE: req_ready_o=1. On a request handshake, latch all request fields and classify the access:
  - Misaligned if addr mod 2^size ≠ 0, or if size=3 with DATA_W=32. Go to RESP with err=1. No bus activity.
  - Store: go to WR_REQ. Load: go to RD_REQ.
- Addressing: m_awaddr_o and m_araddr_o carry the latched address with the low OFF bits cleared.
- Store data: m_wdata_o = wdata << (8·off), where off = addr[OFF-1:0]. m_wstrb_o = ((1<<2^size)−1) << off.
- WR_REQ: m_awvalid_o and m_wvalid_o are asserted.
  - Each valid drops independently on its own ready. Handshakes may occur in either order or in the same cycle.
  - Once both channels have completed, go to WR_RESP.
- WR_RESP: m_bready_o=1. On bvalid, err = bresp[1] (SLVERR/DECERR). Go to RESP.
- RD_REQ: m_arvalid_o=1 until arready, then go to RD_DATA.
- RD_DATA: m_rready_o=1. On rvalid:
  - Shift rdata right by 8·off.
  - Keep the low 2^size bytes and sign- or zero-extend them to DATA_W.
  - err = rresp[1]. Go to RESP.
- Timeout: a counter clears on entry to WR_RESP or RD_DATA. On reaching TIMEOUT_CYC−1 without the response arriving, drop bready/rready and go to RESP with err=1.
  - There is no timeout in WR_REQ or RD_REQ; AXI forbids withdrawing a valid.
- RESP: rsp_valid_o=1 for exactly one cycle. rsp_rdata_o is 0 if err=1 or if the access is a store. Then go to IDLE.
- bready and rready are asserted only in WR_RESP and RD_DATA respectively. A late response after a timeout is not consumed.

## Timing
- Reset state: IDLE. All AXI valid and ready outputs are 0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, and the counter is 0.
- Reset asserted mid-transaction forces these values immediately and asynchronously.
- All outputs are registered or decoded from state; there is no combinational path from input to output.
- With a zero-wait slave and a request accepted at cycle T:
  - AW/W (or AR) valid at T+1, handshake at T+1.
  - B/R at T+2.
  - rsp_valid_o at T+3.
  - req_ready_o high again at T+4.
- Misaligned access accepted at T: rsp_valid_o at T+1.
- req_ready_o is 0 in every state except IDLE. A back-to-back request is taken one cycle after the RESP cycle.

## Test plan
- Aligned word store then load: DATA_W=32, addr 0x100, data 0xDEADBEEF.
  - Store: wstrb=0xF. Load returns 0xDEADBEEF, err=0, rsp_valid_o at T+3.
- Byte store at addr 0x103, data 0x000000A5.
  - wdata=0xA5000000, wstrb=0x8.
  - Signed load at the same address returns 0xFFFFFFA5; unsigned load returns 0x000000A5.
- AW ready 3 cycles before W ready, and the reverse order.
  - Exactly one AW and one W handshake each.
  - WR_RESP is entered only after both channels complete.
- Half load at 0x101 and DATA_W=32 with size=3.
  - No AR/AW activity; rsp_valid_o at T+1, err=1, rdata=0.
- Slave returns rresp=2'b10, then bresp=2'b11.
  - err=1 both times; rdata=0.
- TIMEOUT_CYC=8 and a slave that never asserts rvalid.
  - rsp err=1 exactly 8 cycles after entering RD_DATA, then rready=0.
  - Reset asserted during WR_REQ clears all valids within the same cycle.
